// File: rtl/hit_judge.sv
// Rhythm-game hit judge: latches a target each player time unit, times the
// button press against it and keeps score, combo and best-combo counters.
module hit_judge #(
   parameter int          TOL         = 1,
   parameter logic [31:0] PERFECT_WIN = 32'd1500000,
   parameter logic [31:0] GOOD_WIN    = 32'd3500000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] position,
   input  logic        new_time,
   input  logic [15:0] cursor,
   input  logic        hit_btn,
   input  logic        game_en,
   input  logic        clear,
   output logic [1:0]  judge,
   output logic        judge_valid,
   output logic [15:0] score,
   output logic [7:0]  combo,
   output logic [7:0]  max_combo
);

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_JUDGED} state_t;
   typedef enum logic [1:0] {J_NONE, J_PERFECT, J_GOOD, J_MISS} judge_t;

   localparam logic [15:0] NO_TARGET = 16'hFFFF;

   state_t      state_q, state_d;
   judge_t      judge_q, judge_d, res;
   logic [31:0] timer_q, timer_d;
   logic [15:0] target_q, target_d;
   logic [15:0] score_q, score_d;
   logic [7:0]  combo_q, combo_d;
   logic [7:0]  max_q, max_d;
   logic        btn_d_q;
   logic        valid_q, valid_d;
   logic        btn_edge, fire, positional;
   logic signed [8:0] dx, dy;
   logic [8:0]  adx, ady;
   logic [16:0] score_sum;

   assign btn_edge = hit_btn & ~btn_d_q;

   // Distances are taken as 9-bit signed so that cursor < target works too.
   always_comb begin
      dx  = $signed({1'b0, cursor[15:8]}) - $signed({1'b0, target_q[15:8]});
      dy  = $signed({1'b0, cursor[7:0]})  - $signed({1'b0, target_q[7:0]});
      adx = dx[8] ? 9'(-dx) : 9'(dx);
      ady = dy[8] ? 9'(-dy) : 9'(dy);
      positional = (adx <= 9'(TOL)) && (ady <= 9'(TOL));
   end

   // NOTE: every signal driven here gets a default first so no latch is inferred.
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      target_d  = target_q;
      judge_d   = judge_q;
      valid_d   = 1'b0;
      score_d   = score_q;
      combo_d   = combo_q;
      max_d     = max_q;
      fire      = 1'b0;
      res       = J_NONE;
      score_sum = '0;

      if (!game_en) begin
         state_d = S_IDLE;
      end else if (new_time) begin
         // A same-cycle button edge is dropped; the outgoing target becomes a MISS.
         if (state_q == S_ARMED) begin
            fire = 1'b1;
            res  = J_MISS;
         end
         target_d = position;
         timer_d  = '0;
         state_d  = (position == NO_TARGET) ? S_IDLE : S_ARMED;
      end else if (state_q == S_ARMED) begin
         if (timer_q != '1) timer_d = timer_q + 32'd1;
         if (btn_edge) begin
            fire    = 1'b1;
            state_d = S_JUDGED;
            if (positional && timer_q < PERFECT_WIN)   res = J_PERFECT;
            else if (positional && timer_q < GOOD_WIN) res = J_GOOD;
            else                                       res = J_MISS;
         end
      end

      if (fire) begin
         judge_d = res;
         valid_d = 1'b1;
         if (res == J_MISS) begin
            combo_d = '0;
         end else begin
            score_sum = {1'b0, score_q} + ((res == J_PERFECT) ? 17'd3 : 17'd1);
            score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
            if (combo_q != 8'hFF) combo_d = combo_q + 8'd1;
         end
      end

      if (combo_d > max_q) max_d = combo_d;

      if (clear) begin
         score_d = '0;
         combo_d = '0;
         max_d   = '0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         timer_q  <= '0;
         target_q <= NO_TARGET;
         btn_d_q  <= 1'b0;
         judge_q  <= J_NONE;
         valid_q  <= 1'b0;
         score_q  <= '0;
         combo_q  <= '0;
         max_q    <= '0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         target_q <= target_d;
         btn_d_q  <= hit_btn;
         judge_q  <= judge_d;
         valid_q  <= valid_d;
         score_q  <= score_d;
         combo_q  <= combo_d;
         max_q    <= max_d;
      end
   end

   assign judge       = judge_q;
   assign judge_valid = valid_q;
   assign score       = score_q;
   assign combo       = combo_q;
   assign max_combo   = max_q;

endmodule
